// File: rtl/fact_pkg.sv
// Shared constants, register map and FSM encoding for the factorial accelerator.
package fact_pkg;

    localparam int unsigned FA_DW    = 32;
    localparam int unsigned FA_N_W   = 4;
    localparam int unsigned FA_MAX_N = 12;

    localparam logic [1:0] FA_N    = 2'd0;
    localparam logic [1:0] FA_CTRL = 2'd1;
    localparam logic [1:0] FA_STAT = 2'd2;
    localparam logic [1:0] FA_RES  = 2'd3;

    localparam int unsigned CTRL_GO  = 0;
    localparam int unsigned CTRL_CLR = 1;

    localparam int unsigned STAT_DONE = 0;
    localparam int unsigned STAT_ERR  = 1;
    localparam int unsigned STAT_BUSY = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fa_state_t;

endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: accumulator, down-counter, one multiply per step.
module fact_dp
    import fact_pkg::*;
#(
    parameter int unsigned N_W = FA_N_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             zero_res,
    input  logic [N_W-1:0]   n,
    output logic [FA_DW-1:0] acc,
    output logic             last
);

    logic [N_W-1:0]   cnt;
    logic [FA_DW-1:0] prod;

    // Truncated 32 x N_W product; cannot overflow for legal operands.
    assign prod = acc * FA_DW'(cnt);
    assign last = (cnt <= N_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= FA_DW'(1);
            cnt <= '0;
        end else if (zero_res) begin
            acc <= '0;
        end else if (load) begin
            acc <= FA_DW'(1);
            cnt <= n;
        end else if (step) begin
            acc <= prod;
            cnt <= cnt - N_W'(1);
        end
    end

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator: bus decode, N register,
// done/err flags and the IDLE/BUSY/DONE controller around fact_dp.
module fact_accel
    import fact_pkg::*;
#(
    parameter int unsigned N_W   = FA_N_W,
    parameter int unsigned MAX_N = FA_MAX_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [FA_DW-1:0] wd,
    output logic [FA_DW-1:0] rd,
    output logic             busy,
    output logic             done
);

    fa_state_t        state_q, state_d;
    logic [N_W-1:0]   n_q;
    logic             done_q, err_q, busy_q;
    logic [1:0]       sel;
    logic             wr_n, go, clr, over;
    logic             load, step, zero_res, set_done, set_err, clr_flags;
    logic [FA_DW-1:0] acc;
    logic             last;
    logic             unused_bits;

    assign sel  = addr[3:2];
    assign wr_n = we && (sel == FA_N);
    assign go   = we && (sel == FA_CTRL) && wd[CTRL_GO];
    assign clr  = we && (sel == FA_CTRL) && wd[CTRL_CLR];
    assign over = (32'(n_q) > MAX_N);

    // Byte-lane address bits and upper write-data bits carry no meaning here.
    assign unused_bits = ^{addr[1:0], wd};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; GO outranks a simultaneous clear.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        zero_res  = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        clr_flags = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    state_d = ST_DONE;
                    if (over) begin
                        zero_res = 1'b1;
                        set_done = 1'b1;
                        set_err  = 1'b1;
                    end else begin
                        load      = 1'b1;
                        clr_flags = 1'b1;
                        state_d   = ST_BUSY;
                    end
                end else if (clr) begin
                    clr_flags = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last) begin
                    set_done = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            if (wr_n) begin
                n_q <= wd[N_W-1:0];
            end
            busy_q <= (state_d == ST_BUSY);
            if (clr_flags) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (set_done) begin
                done_q <= 1'b1;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    fact_dp #(
        .N_W (N_W)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .zero_res (zero_res),
        .n        (n_q),
        .acc      (acc),
        .last     (last)
    );

    // Combinational read mux over the current register contents.
    always_comb begin
        rd = '0;
        case (sel)
            FA_N:    rd = FA_DW'(n_q);
            FA_CTRL: rd = '0;
            FA_STAT: begin
                rd[STAT_DONE] = done_q;
                rd[STAT_ERR]  = err_q;
                rd[STAT_BUSY] = busy_q;
            end
            FA_RES:  rd = acc;
            default: rd = '0;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_fact_accel.sv
// Scoreboard bench for fact_accel: GO pushes the expected result and latency,
// completion pops and compares them.
module tb_fact_accel;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        we   = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] wd   = 32'd0;
    logic [31:0] rd;
    logic        busy;
    logic        done;

    int n_chk   = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    int t_go    = 0;

    logic [31:0] sb_q[$];
    int          lat_q[$];
    logic [31:0] fact_tbl [0:12] = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120,
                                     32'd720, 32'd5040, 32'd40320, 32'd362880,
                                     32'd3628800, 32'd39916800, 32'd479001600};

    fact_accel dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .wd   (wd),
        .rd   (rd),
        .busy (busy),
        .done (done)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_fact(input int n);
        if (n > 12) return 32'd0;
        return fact_tbl[n];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
        @(negedge clk);
        we   = 1'b1;
        addr = {r, 2'b00};
        wd   = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        wd = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] v);
        addr = {r, 2'b11};
        #1;
        v = rd;
    endtask

    task automatic start_go(input int n, input logic [31:0] ctrl);
        sb_q.push_back(exp_fact(n));
        lat_q.push_back((n < 1) ? 1 : n);
        bus_write(2'd1, ctrl);
        t_go = cyc_cnt;
    endtask

    task automatic finish_run(input string tag, input bit chk_busy);
        int          guard = 0;
        int          busy_n = 0;
        int          lat;
        logic [31:0] v;
        logic [31:0] exp_res = 32'd0;
        int          exp_lat = 0;
        while (!done && guard < 100) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            guard++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        lat = cyc_cnt - t_go;
        if (sb_q.size() > 0) exp_res = sb_q.pop_front();
        if (lat_q.size() > 0) exp_lat = lat_q.pop_front();
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (chk_busy) check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
        bus_read(2'd3, v);
        check({tag, "_result"}, v, exp_res);
        bus_read(2'd2, v);
        check({tag, "_status"}, v, 32'h1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] v;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus_read(2'd0, v); check("rst_n",      v, 32'd0);
        bus_read(2'd1, v); check("rst_ctrl",   v, 32'd0);
        bus_read(2'd2, v); check("rst_status", v, 32'd0);
        bus_read(2'd3, v); check("rst_result", v, 32'd1);

        // N=5 with upper bits set on the write
        bus_write(2'd0, 32'hABCD_0005);
        bus_read(2'd0, v); check("n_masked", v, 32'd5);
        start_go(5, 32'h1);
        finish_run("n5", 1'b1);

        // Sweep 0..12; n=6 starts from DONE with GO+CLR together
        for (int n = 0; n <= 12; n++) begin
            if (n != 6) begin
                bus_write(2'd1, 32'h2);
                bus_read(2'd2, v); check($sformatf("clr%0d_status", n), v, 32'd0);
            end
            bus_write(2'd0, 32'(n));
            start_go(n, (n == 6) ? 32'h3 : 32'h1);
            finish_run($sformatf("sweep%0d", n), 1'b1);
        end

        // Out-of-range operand
        bus_write(2'd1, 32'h2);
        bus_write(2'd0, 32'd13);
        sb_q.push_back(exp_fact(13));
        bus_write(2'd1, 32'h1);
        bus_read(2'd2, v); check("err_status", v, 32'h3);
        bus_read(2'd3, v); check("err_result", v, sb_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            check($sformatf("err_busy%0d", i), 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end

        // Restart from error DONE without a clear
        bus_write(2'd0, 32'd2);
        start_go(2, 32'h1);
        finish_run("after_err", 1'b1);

        // GO and N write while BUSY
        bus_write(2'd1, 32'h2);
        bus_write(2'd0, 32'd7);
        start_go(7, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        bus_write(2'd1, 32'h1);
        bus_read(2'd2, v); check("ign_go_status", v, 32'h4);
        bus_write(2'd0, 32'd3);
        finish_run("n7_ignored_go", 1'b0);
        bus_read(2'd0, v); check("n7_nreg", v, 32'd3);

        // Reset in the middle of a computation
        bus_write(2'd1, 32'h2);
        bus_write(2'd0, 32'd12);
        bus_write(2'd1, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        bus_read(2'd0, v); check("midrst_n",      v, 32'd0);
        bus_read(2'd2, v); check("midrst_status", v, 32'd0);
        bus_read(2'd3, v); check("midrst_result", v, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        bus_write(2'd0, 32'd4);
        start_go(4, 32'h1);
        finish_run("post_rst", 1'b1);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fact_accel.md
# fact_accel

Memory-mapped iterative factorial accelerator on the MIPS system data bus. It is the responder side of the factorial exchange: the CPU (initiator) writes an operand and a start command, polls status, then reads the result. It sits in `system` beside the GPIO registers, decoded from the data-memory address space, so factorial firmware can offload the multiply loop.

## Interface
- `N_W`, default 4: operand width in bits.
- `MAX_N`, default 12: largest operand whose factorial fits in 32 bits. Larger operands flag an error.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset. Assertion takes effect immediately; release is synchronous to `clk` at system level.
- `we` input 1: bus write strobe, sampled on the `clk` rising edge.
- `addr` input 4: byte address. Only `addr[3:2]` is decoded; `addr[1:0]` is ignored.
- `wd` input 32: bus write data.
- `rd` output 32: bus read data, combinational from `addr`.
- `busy` output 1: computation in progress.
- `done` output 1: sticky completion flag.

## Operation
- Register map by `addr[3:2]`:
  - 0 N: read/write. Holds the operand in bits `[N_W-1:0]`; upper bits are ignored on write and read back as 0.
  - 1 CTRL: write-only, reads 0. Writing bit0=1 is GO. Writing bit1=1 clears `done` and `err`.
  - 2 STATUS: read-only. Bit0=`done`, bit1=`err`, bit2=`busy`; other bits read 0.
  - 3 RESULT: read-only. The 32-bit factorial value.
- FSM states are IDLE, BUSY and DONE.
  - IDLE or DONE, on GO:
    - If N > `MAX_N`: go to DONE with `err`=1, RESULT=0, `done`=1.
    - Otherwise: `cnt`←N, `acc`←1, `done`←0, `err`←0, go to BUSY.
  - BUSY:
    - If `cnt` ≤ 1: go to DONE and set `done`=1.
    - Otherwise: `acc`←`acc`×`cnt` (low 32 bits), `cnt`←`cnt`−1.
  - DONE: hold RESULT=`acc`. A clear write (CTRL bit1) goes to IDLE with `done`=`err`=0. GO restarts as described for IDLE.
- A GO while BUSY is ignored: no state, count or flag change.
- A write to N while BUSY updates the N register only. The running computation uses its captured `cnt`.
- CTRL write with bit0=1 and bit1=1 together: GO wins, and the clear is implied by GO.
- RESULT reads `acc` in all states. Its value is only meaningful when `done`=1 and `err`=0.
- N=0 and N=1 both return 1.

## Timing
- Reset values: `rd` reflects reset registers, so N=0, RESULT=1, STATUS=0. `busy`=0, `done`=0, state IDLE, `acc`=1, `cnt`=0.
- GO captured at edge t0:
  - For N ≤ `MAX_N`: `busy`=1 after t0. `done`=1 and `busy`=0 after edge t(max(N,1)). Total latency is max(N,1) cycles.
  - For N > `MAX_N`: `done`=`err`=1 after t0 (1 cycle), and `busy` stays 0.
- At most one multiply per cycle. The product is a 32×`N_W` multiply truncated to 32 bits; no overflow can occur for N ≤ `MAX_N`.
- `rd` is combinational. A read in the same cycle as the completing edge shows the pre-edge values.
- Reset asserted mid-BUSY aborts immediately to reset values. No partial result is retained.

## Structure
- Shared package `fact_pkg`:
  - Register offsets `FA_N`=0, `FA_CTRL`=1, `FA_STAT`=2, `FA_RES`=3.
  - CTRL/STATUS bit positions.
  - FSM state encoding.
  - `MAX_N`.
- One sub-module, `fact_dp`: holds the `acc`/`cnt` registers, the multiplier and the `cnt` ≤ 1 compare. Controls are `load`, `step`, `zero_res`; output is `last`.
- The top level contains the bus decode, the N register, the flags and the FSM.

## Test plan
- Reset, then read all four registers → N=0, CTRL=0, STATUS=0, RESULT=1.
- Write N=5, GO, poll → `busy` for exactly 5 cycles, then STATUS=0x1, RESULT=120.
- Sweep N=0..12, each preceded by a clear → RESULT matches 1,1,2,6,…,479001600. Latency is max(N,1) cycles.
- Write N=13, GO → STATUS=0x3 one cycle later, RESULT=0, `busy` never 1.
- N=7, GO, then after 2 cycles issue GO again and write N=3 → GO ignored, final RESULT=5040, N reads 3.
- N=12, GO, assert `rst` low at cycle 4 → outputs take reset values immediately. After release, a fresh N=4 GO yields 24.
